// File: rtl/mt_pkg.sv
// rtl/mt_pkg.sv - Mersenne Twister shared types, MT19937 / MT19937-64 constant sets, tempering helper
//
// Contents:
//   mt_state_e   generator FSM state (ST_SEED, ST_RUN)
//   MT32_*       MT19937 constant set (W, N, M, R, A, F, U, D, S, B, T, C, L)
//   MT64_*       MT19937-64 constant set
//   mt_wmask     all-ones mask of the low w bits of a 64-bit word
//   mt_temper    tempering transform on a 64-bit carrier, result masked to the word width

package mt_pkg;

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } mt_state_e;

    localparam int          MT32_W = 32;
    localparam int          MT32_N = 624;
    localparam int          MT32_M = 397;
    localparam int          MT32_R = 31;
    localparam logic [63:0] MT32_A = 64'h0000_0000_9908_b0df;
    localparam logic [63:0] MT32_F = 64'd1812433253;
    localparam int          MT32_U = 11;
    localparam logic [63:0] MT32_D = 64'h0000_0000_ffff_ffff;
    localparam int          MT32_S = 7;
    localparam logic [63:0] MT32_B = 64'h0000_0000_9d2c_5680;
    localparam int          MT32_T = 15;
    localparam logic [63:0] MT32_C = 64'h0000_0000_efc6_0000;
    localparam int          MT32_L = 18;

    localparam int          MT64_W = 64;
    localparam int          MT64_N = 312;
    localparam int          MT64_M = 156;
    localparam int          MT64_R = 31;
    localparam logic [63:0] MT64_A = 64'hb502_6f5a_a966_19e9;
    localparam logic [63:0] MT64_F = 64'd6364136223846793005;
    localparam int          MT64_U = 29;
    localparam logic [63:0] MT64_D = 64'h5555_5555_5555_5555;
    localparam int          MT64_S = 17;
    localparam logic [63:0] MT64_B = 64'h71d6_7fff_eda6_0000;
    localparam int          MT64_T = 37;
    localparam logic [63:0] MT64_C = 64'hfff7_eee0_0000_0000;
    localparam int          MT64_L = 43;

    // For w == 64 the shift yields zero and the subtraction wraps to all ones.
    function automatic logic [63:0] mt_wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] mt_temper(
        input logic [63:0] y_in,
        input logic [63:0] wmask,
        input int          u,
        input logic [63:0] d,
        input int          s,
        input logic [63:0] b,
        input int          t,
        input logic [63:0] c,
        input int          l
    );
        logic [63:0] y;
        y = y_in & wmask;
        y = y ^ ((y >> u) & d);
        y = y ^ (((y << s) & b) & wmask);
        y = y ^ (((y << t) & c) & wmask);
        y = y ^ (y >> l);
        return y & wmask;
    endfunction

endpackage

// File: rtl/mt_state_mem.sv
// rtl/mt_state_mem.sv - N x W generator state array, three async read ports, one sync write port
//
// Ports:
//   clk                          clock
//   we, waddr, wdata             synchronous write port
//   raddr_a/b/c, rdata_a/b/c     asynchronous read ports (current, next, middle word)
// Contents are not reset; the seeding pass rewrites every word before use.

module mt_state_mem #(
    parameter int W  = 32,
    parameter int N  = 624,
    parameter int IW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] raddr_a,
    input  logic [IW-1:0] raddr_b,
    input  logic [IW-1:0] raddr_c,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b,
    output logic [W-1:0]  rdata_c
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/mt_rng_core.sv
// rtl/mt_rng_core.sv - Parametrised Mersenne Twister core: seeding FSM, per-word twist, tempering, valid/ready output
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   seed       seed word, used in the first cycle after reset release (and on re_seed)
//   re_seed    reseed request, honoured only when MT_RESEED_EN is defined
//   rnd        tempered output word
//   rnd_valid  rnd holds an unconsumed word
//   rnd_ready  consumer takes rnd this cycle
//   busy       seeding in progress
// Build option: MT_RESEED_EN enables re_seed; without it re_seed is ignored.

module mt_rng_core
    import mt_pkg::*;
#(
    parameter int          W = MT32_W,
    parameter int          N = MT32_N,
    parameter int          M = MT32_M,
    parameter int          R = MT32_R,
    parameter logic [63:0] A = MT32_A,
    parameter logic [63:0] F = MT32_F,
    parameter int          U = MT32_U,
    parameter logic [63:0] D = MT32_D,
    parameter int          S = MT32_S,
    parameter logic [63:0] B = MT32_B,
    parameter int          T = MT32_T,
    parameter logic [63:0] C = MT32_C,
    parameter int          L = MT32_L
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] seed,
    input  logic         re_seed,
    output logic [W-1:0] rnd,
    output logic         rnd_valid,
    input  logic         rnd_ready,
    output logic         busy
);

    localparam int           IW     = $clog2(N);
    localparam logic [63:0]  WMASK  = mt_wmask(W);
    localparam logic [W-1:0] LOWER  = W'((64'd1 << R) - 64'd1);
    localparam logic [W-1:0] UPPER  = ~LOWER;
    localparam logic [W-1:0] A_W    = A[W-1:0];
    localparam logic [W-1:0] F_W    = F[W-1:0];
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [IW:0]  M_EXT  = (IW + 1)'(M);
    localparam logic [IW:0]  N_EXT  = (IW + 1)'(N);

    mt_state_e     state_q;
    mt_state_e     state_d;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  prev_q;
    logic [W-1:0]  seed_hold_q;
    logic          use_hold_q;

    logic          reseed_req;
    logic          step;
    logic          mem_we;
    logic [W-1:0]  mem_wdata;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] idx_mid;
    logic [IW:0]   mid_sum;
    logic [W-1:0]  rd_cur;
    logic [W-1:0]  rd_nxt;
    logic [W-1:0]  rd_mid;
    logic [W-1:0]  seed_word;
    logic [W-1:0]  seed_next;
    logic [W-1:0]  twist_y;
    logic [W-1:0]  twist_word;
    logic [W-1:0]  rnd_next;

`ifdef MT_RESEED_EN
    assign reseed_req = re_seed;
`else
    logic unused_re_seed;
    assign unused_re_seed = re_seed;
    assign reseed_req     = 1'b0;
`endif

    // Circular neighbours of idx: idx+1 and idx+M, both mod N.
    assign idx_nxt = (idx_q == LAST) ? '0 : idx_q + IW'(1);
    assign mid_sum = {1'b0, idx_q} + M_EXT;
    assign idx_mid = (mid_sum >= N_EXT) ? IW'(mid_sum - N_EXT) : mid_sum[IW-1:0];

    mt_state_mem #(
        .W  (W),
        .N  (N),
        .IW (IW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (idx_q),
        .wdata   (mem_wdata),
        .raddr_a (idx_q),
        .raddr_b (idx_nxt),
        .raddr_c (idx_mid),
        .rdata_a (rd_cur),
        .rdata_b (rd_nxt),
        .rdata_c (rd_mid)
    );

    // A reseed latches the seed so the restarted k=0 step uses the value
    // present in the request cycle, not whatever sits on the port later.
    assign seed_word  = use_hold_q ? seed_hold_q : seed;
    assign seed_next  = F_W * (prev_q ^ (prev_q >> (W - 2))) + W'(idx_q);

    // Lazy twist: mt[idx+1] is still the old word, mt[idx+M] is already
    // updated once idx+M wraps, which is exactly the block-twist ordering.
    assign twist_y    = (rd_cur & UPPER) | (rd_nxt & LOWER);
    assign twist_word = rd_mid ^ (twist_y >> 1) ^ (twist_y[0] ? A_W : '0);
    assign rnd_next   = W'(mt_temper(64'(twist_word), WMASK, U, D, S, B, T, C, L));

    assign busy = (state_q == ST_SEED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step      = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (reseed_req) begin
            state_d = ST_SEED;
        end else begin
            case (state_q)
                ST_SEED: begin
                    mem_we    = 1'b1;
                    mem_wdata = (idx_q == '0) ? seed_word : seed_next;
                    if (idx_q == LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    step      = !rnd_valid || rnd_ready;
                    mem_we    = step;
                    mem_wdata = twist_word;
                end
                default: begin
                    state_d = ST_SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            prev_q      <= '0;
            seed_hold_q <= '0;
            use_hold_q  <= 1'b0;
            rnd         <= '0;
            rnd_valid   <= 1'b0;
        end else if (reseed_req) begin
            idx_q       <= '0;
            seed_hold_q <= seed;
            use_hold_q  <= 1'b1;
            rnd_valid   <= 1'b0;
        end else if (state_q == ST_SEED) begin
            prev_q <= mem_wdata;
            idx_q  <= idx_nxt;
        end else if (step) begin
            rnd       <= rnd_next;
            rnd_valid <= 1'b1;
            idx_q     <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_mt_rng_core.sv
// tb/tb_mt_rng_core.sv - Self-checking bench for mt_rng_core against a block-twist reference model

module tb_mt_rng_core;
    import mt_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        re_seed;
    logic        rnd_ready;
    logic        rnd_valid;
    logic        busy;
    logic [31:0] seed;
    logic [31:0] rnd;

    logic        rnd_ready64;
    logic        rnd_valid64;
    logic        busy64;
    logic [63:0] seed64;
    logic [63:0] rnd64;

    int errors = 0;
    int checks = 0;

    logic [63:0] ref_mt [624];
    int          ref_i;
    int          mw, mn, mm, mr, mu, ms, mtt, ml;
    logic [63:0] ma, mf, md, mb, mc, mmask;
    logic [63:0] acc_q [$];

    mt_rng_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed      (seed),
        .re_seed   (re_seed),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy)
    );

    mt_rng_core #(
        .W (MT64_W), .N (MT64_N), .M (MT64_M), .R (MT64_R), .A (MT64_A), .F (MT64_F),
        .U (MT64_U), .D (MT64_D), .S (MT64_S), .B (MT64_B), .T (MT64_T), .C (MT64_C), .L (MT64_L)
    ) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed      (seed64),
        .re_seed   (1'b0),
        .rnd       (rnd64),
        .rnd_valid (rnd_valid64),
        .rnd_ready (rnd_ready64),
        .busy      (busy64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_cfg(input bit is64);
        if (is64) begin
            mw = 64; mn = 312; mm = 156; mr = 31;
            ma = 64'hb5026f5aa96619e9; mf = 64'd6364136223846793005;
            mu = 29; md = 64'h5555555555555555; ms = 17; mb = 64'h71d67fffeda60000;
            mtt = 37; mc = 64'hfff7eee000000000; ml = 43;
            mmask = '1;
        end else begin
            mw = 32; mn = 624; mm = 397; mr = 31;
            ma = 64'h9908b0df; mf = 64'd1812433253;
            mu = 11; md = 64'hffffffff; ms = 7; mb = 64'h9d2c5680;
            mtt = 15; mc = 64'hefc60000; ml = 18;
            mmask = 64'hffffffff;
        end
    endtask

    function automatic void model_seed(input logic [63:0] s);
        ref_mt[0] = s & mmask;
        for (int i = 1; i < mn; i++) begin
            ref_mt[i] = (mf * (ref_mt[i-1] ^ (ref_mt[i-1] >> (mw - 2))) + 64'(i)) & mmask;
        end
        ref_i = mn;
    endfunction

    // Reference generator: regenerate the whole state block at once, then temper.
    function automatic logic [63:0] model_next();
        logic [63:0] y;
        logic [63:0] lower;
        logic [63:0] upper;
        lower = (64'd1 << mr) - 64'd1;
        upper = mmask & ~lower;
        if (ref_i >= mn) begin
            for (int i = 0; i < mn; i++) begin
                y = (ref_mt[i] & upper) | (ref_mt[(i + 1) % mn] & lower);
                ref_mt[i] = ref_mt[(i + mm) % mn] ^ (y >> 1) ^ (y[0] ? ma : 64'd0);
            end
            ref_i = 0;
        end
        y = ref_mt[ref_i];
        ref_i++;
        y = y ^ ((y >> mu) & md);
        y = y ^ ((y << ms) & mb);
        y = y ^ ((y << mtt) & mc);
        y = y ^ (y >> ml);
        return y & mmask;
    endfunction

    task automatic restart(input logic [31:0] s, output int lat, output int busy_cnt);
        seed  = s;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset_valid", 64'(rnd_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_rnd", 64'(rnd), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        while (!rnd_valid && lat < 2000) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check("fill_timeout", 64'(rnd_valid), 64'd1);
    endtask

    task automatic collect(input int count, input bit stall, input string tag);
        int          got_n;
        int          cyc;
        bit          rdy;
        bit          held_v;
        logic [31:0] held;
        got_n  = 0;
        cyc    = 0;
        held_v = 1'b0;
        held   = '0;
        acc_q.delete();
        while (got_n < count && cyc < count * 8 + 100) begin
            rdy       = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            rnd_ready = rdy;
            check("valid_held", 64'(rnd_valid), 64'd1);
            if (held_v) check("stall_stable", 64'(rnd), 64'(held));
            if (rdy) begin
                check(tag, 64'(rnd), model_next());
                acc_q.push_back(64'(rnd));
                got_n++;
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held   = rnd;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("collect_count", 64'(got_n), 64'(count));
    endtask

    initial begin
        int lat;
        int bc;
        rst_n       = 1'b0;
        re_seed     = 1'b0;
        rnd_ready   = 1'b1;
        rnd_ready64 = 1'b0;
        seed        = 32'd5489;
        seed64      = 64'd5489;
        model_cfg(1'b0);

        // Default seed, full throughput
        restart(32'd5489, lat, bc);
        check("busy_cycles", 64'(bc), 64'd624);
        check("first_valid_latency", 64'(lat), 64'd625);
        check("t1_first", 64'(rnd), 64'd3499211612);
        model_seed(64'd5489);
        collect(1000, 1'b0, "t1_word");
        check("t1_second", acc_q[1], 64'd581869302);

        // Seed 1, long run across several index wraps
        restart(32'd1, lat, bc);
        check("t2_first", 64'(rnd), 64'd1791095845);
        model_seed(64'd1);
        collect(2000, 1'b0, "t2_word");

        // Random consumer stalls
        restart(32'd5489, lat, bc);
        model_seed(64'd5489);
        collect(700, 1'b1, "t4_word");

        // Reset mid-run at word 700
        restart(32'd5489, lat, bc);
        check("t5_first", 64'(rnd), 64'd3499211612);
        model_seed(64'd5489);
        collect(50, 1'b0, "t5_word");

        // Reseed request during RUN with consumer ready
        seed      = 32'd1;
        re_seed   = 1'b1;
        rnd_ready = 1'b1;
        check("t6_valid_before", 64'(rnd_valid), 64'd1);
`ifndef MT_RESEED_EN
        check("t6_consumed", 64'(rnd), model_next());
`endif
        @(posedge clk); #1;
        re_seed = 1'b0;
`ifdef MT_RESEED_EN
        check("t6_valid_drop", 64'(rnd_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd1);
        lat = 0;
        bc  = 0;
        while (!rnd_valid && lat < 2000) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
        check("t6_timeout", 64'(rnd_valid), 64'd1);
        check("t6_reseed_busy", 64'(bc), 64'd624);
        check("t6_first", 64'(rnd), 64'd1791095845);
        model_seed(64'd1);
`else
        check("t6_valid_kept", 64'(rnd_valid), 64'd1);
        check("t6_not_busy", 64'(busy), 64'd0);
`endif
        collect(200, 1'b0, "t6_word");

        // 64-bit MT19937-64 instance
        rnd_ready   = 1'b0;
        rnd_ready64 = 1'b0;
        model_cfg(1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t3_reset_valid", 64'(rnd_valid64), 64'd0);
        check("t3_reset_busy", 64'(busy64), 64'd1);
        rst_n = 1'b1;
        lat   = 0;
        while (!rnd_valid64 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t3_latency", 64'(lat), 64'd313);
        check("t3_first", rnd64, 64'd14514284786278117030);
        model_seed(64'd5489);
        rnd_ready64 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            check("t3_word", rnd64, model_next());
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
